// File: rtl/alu_pkg.sv
// ============================================================================
//  alu_pkg : shared opcode/state encodings and default widths for the ALU
//  Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int DEFAULT_IDATA_WIDTH   = 64;
  localparam int DEFAULT_ALU_OPP_WIDTH = 2;

  typedef enum logic [1:0] {
    OP_SUM  = 2'd0,
    OP_MULT = 2'd1,
    OP_DIV  = 2'd2,
    OP_RSVD = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_OUT  = 2'd2
  } alu_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_divider.sv
// ============================================================================
//  alu_divider : unsigned restoring divider, one quotient bit per cycle
//  Revision: 1.0
// ============================================================================
`default_nettype none

module alu_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_IDATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] step_rem_in, step_quo_in, step_dsr;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic             step_bit;

  // The start cycle already performs the first iteration on the raw inputs,
  // so the last quotient bit lands WIDTH-1 edges after start.
  always_comb begin
    step_rem_in = rem_q;
    step_quo_in = quo_q;
    step_dsr    = dsr_q;
    if (start) begin
      step_rem_in = '0;
      step_quo_in = dividend;
      step_dsr    = divisor;
    end
    rem_sh   = {step_rem_in, step_quo_in[WIDTH-1]};
    step_bit = (rem_sh >= {1'b0, step_dsr});
    step_rem = step_bit ? (rem_sh[WIDTH-1:0] - step_dsr) : rem_sh[WIDTH-1:0];
    step_quo = {step_quo_in[WIDTH-2:0], step_bit};
  end

  assign done     = busy_q && (cnt_q == CNT_W'(WIDTH));
  assign busy     = busy_q;
  // A zero divisor makes every trial subtraction succeed, giving all ones.
  assign quotient = quo_q;

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      rem_d  = step_rem;
      quo_d  = step_quo;
      dsr_d  = divisor;
      cnt_d  = CNT_W'(1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (done) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
//  alu : single-operation AXI-Stream SUM/MULT/DIV unit with pulsed result
//  Revision: 1.0
// ============================================================================
`default_nettype none

module alu
  import alu_pkg::*;
#(
  parameter int IDATA_WIDTH   = DEFAULT_IDATA_WIDTH,
  parameter int ALU_OPP_WIDTH = DEFAULT_ALU_OPP_WIDTH
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [ALU_OPP_WIDTH-1:0] i_alu_opp,
  input  logic [IDATA_WIDTH-1:0]   s_axis_a_tdata,
  input  logic                     s_axis_a_tvalid,
  output logic                     s_axis_a_tready,
  input  logic [IDATA_WIDTH-1:0]   s_axis_b_tdata,
  output logic [IDATA_WIDTH-1:0]   m_axis_result_tdata,
  output logic                     m_axis_result_tvalid
);

  alu_state_e             state_q, state_d;
  alu_op_e                op_q, op_d;
  logic [IDATA_WIDTH-1:0] a_q, a_d;
  logic [IDATA_WIDTH-1:0] b_q, b_d;
  logic [IDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tready_q, tready_d;

  alu_op_e                op_in;
  logic                   accept;
  logic                   div_start, div_busy, div_done;
  logic [IDATA_WIDTH-1:0] div_quotient;
  logic [IDATA_WIDTH-1:0] result;

  assign op_in     = alu_op_e'(i_alu_opp[1:0]);
  assign accept    = s_axis_a_tvalid && tready_q;
  assign div_start = accept && (op_in == OP_DIV);

  // Divider takes operands straight from the ports so its first step
  // coincides with the accept edge.
  alu_divider #(
    .WIDTH (IDATA_WIDTH)
  ) u_divider (
    .clk      (aclk),
    .rst_n    (aresetn),
    .start    (div_start),
    .dividend (s_axis_a_tdata),
    .divisor  (s_axis_b_tdata),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_comb begin
    result = '0;
    case (op_q)
      OP_SUM:  result = a_q + b_q;
      OP_MULT: result = a_q * b_q;
      OP_DIV:  result = div_quotient;
      default: result = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    tdata_d  = tdata_q;
    tvalid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d     = s_axis_a_tdata;
          b_d     = s_axis_b_tdata;
          op_d    = op_in;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if ((op_q != OP_DIV) || div_done) begin
          tdata_d  = result;
          tvalid_d = 1'b1;
          state_d  = ST_OUT;
        end
      end
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    tready_d = (state_d == ST_IDLE) && !div_busy;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_SUM;
      a_q      <= '0;
      b_q      <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tready_q <= tready_d;
    end
  end

  assign s_axis_a_tready      = tready_q;
  assign m_axis_result_tdata  = tdata_q;
  assign m_axis_result_tvalid = tvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// ============================================================================
//  tb_alu : directed self-checking bench for alu
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu;

  logic        aclk;
  logic        aresetn;
  logic [1:0]  i_alu_opp;
  logic [63:0] a_tdata;
  logic        a_tvalid;
  logic        a_tready;
  logic [63:0] b_tdata;
  logic [63:0] r_tdata;
  logic        r_tvalid;

  int checks = 0;
  int errors = 0;

  alu #(
    .IDATA_WIDTH   (64),
    .ALU_OPP_WIDTH (2)
  ) dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .i_alu_opp            (i_alu_opp),
    .s_axis_a_tdata       (a_tdata),
    .s_axis_a_tvalid      (a_tvalid),
    .s_axis_a_tready      (a_tready),
    .s_axis_b_tdata       (b_tdata),
    .m_axis_result_tdata  (r_tdata),
    .m_axis_result_tvalid (r_tvalid)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one operand pair at a negedge, scramble inputs after accept,
  // then measure latency, result, and pulse width.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int lat);
    int n;
    n = 0;
    while (!a_tready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    check_value({tag, "_ready"}, 64'(a_tready), 64'd1);
    i_alu_opp = op;
    a_tdata   = a;
    b_tdata   = b;
    a_tvalid  = 1'b1;
    @(negedge aclk);
    a_tvalid  = 1'b0;
    i_alu_opp = ~op;
    a_tdata   = ~a;
    b_tdata   = ~b;
    check_value({tag, "_tready_drop"}, 64'(a_tready), 64'd0);
    n = 0;
    while (!r_tvalid && n < 200) begin
      @(negedge aclk);
      n++;
    end
    check_value({tag, "_latency"}, 64'(n), 64'(lat));
    check_value({tag, "_data"}, r_tdata, exp);
    @(negedge aclk);
    check_value({tag, "_pulse_end"}, 64'(r_tvalid), 64'd0);
    check_value({tag, "_data_hold"}, r_tdata, exp);
  endtask

  initial begin
    int pulses;
    aresetn   = 1'b0;
    i_alu_opp = 2'd0;
    a_tdata   = '0;
    b_tdata   = '0;
    a_tvalid  = 1'b0;

    repeat (3) @(negedge aclk);
    check_value("rst_tready", 64'(a_tready), 64'd0);
    check_value("rst_tvalid", 64'(r_tvalid), 64'd0);
    check_value("rst_tdata", r_tdata, 64'd0);
    aresetn = 1'b1;
    #1;
    check_value("rel_tready_pre", 64'(a_tready), 64'd0);
    @(negedge aclk);
    check_value("rel_tready_post", 64'(a_tready), 64'd1);

    do_op("sum_19_48",  2'd0, 64'd19, 64'd48, 64'd67, 1);
    do_op("mult_19_48", 2'd1, 64'd19, 64'd48, 64'd912, 1);
    do_op("div_19_48",  2'd2, 64'd19, 64'd48, 64'd0, 64);
    do_op("div_48_19",  2'd2, 64'd48, 64'd19, 64'd2, 64);
    do_op("div_by_0",   2'd2, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64);
    do_op("div_big",    2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0001, 64'hFFFF_FFFF, 64);
    do_op("sum_wrap",   2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1);
    do_op("mult_trunc", 2'd1, 64'h8000_0000_0000_0000, 64'd2, 64'd0, 1);
    do_op("sum_3_4",    2'd0, 64'd3, 64'd4, 64'd7, 1);
    do_op("rsvd",       2'd3, 64'd5, 64'd6, 64'd0, 1);

    // tvalid held through CALC/OUT: only one capture, opcode change ignored
    i_alu_opp = 2'd0;
    a_tdata   = 64'd5;
    b_tdata   = 64'd7;
    a_tvalid  = 1'b1;
    @(negedge aclk);
    i_alu_opp = 2'd1;
    check_value("hold_tready_calc", 64'(a_tready), 64'd0);
    check_value("hold_tvalid_calc", 64'(r_tvalid), 64'd0);
    @(negedge aclk);
    check_value("hold_tvalid_out", 64'(r_tvalid), 64'd1);
    check_value("hold_data", r_tdata, 64'd12);
    check_value("hold_tready_out", 64'(a_tready), 64'd0);
    @(negedge aclk);
    a_tvalid = 1'b0;
    check_value("hold_tvalid_low", 64'(r_tvalid), 64'd0);
    check_value("hold_tready_back", 64'(a_tready), 64'd1);
    pulses = 0;
    repeat (4) begin
      @(negedge aclk);
      if (r_tvalid) pulses++;
    end
    check_value("hold_no_second", 64'(pulses), 64'd0);

    // reset in the middle of a division
    i_alu_opp = 2'd2;
    a_tdata   = 64'd1000;
    b_tdata   = 64'd3;
    a_tvalid  = 1'b1;
    @(negedge aclk);
    a_tvalid = 1'b0;
    repeat (10) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check_value("midrst_tvalid", 64'(r_tvalid), 64'd0);
    check_value("midrst_tdata", r_tdata, 64'd0);
    check_value("midrst_tready", 64'(a_tready), 64'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    pulses = 0;
    repeat (80) begin
      @(negedge aclk);
      if (r_tvalid) pulses++;
    end
    check_value("midrst_no_pulse", 64'(pulses), 64'd0);
    do_op("post_rst_sum", 2'd0, 64'd1, 64'd1, 64'd2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
